mux_vec_checker: RTL and testbench
==================================

# mux_vec_checker

Self-checking stimulus stage that sits upstream of, and closes the loop around, the 3-input select/compare combinational block (inputs x1, x2, x3; output f). On a start pulse it walks all eight input vectors onto x1/x2/x3, waits a programmable settle time, samples f, and compares it against the golden function f = ~(x2 ? x1 : x3). It then presents an error count, the first failing vector and a pass flag through a valid/ready result handshake.

## Interface
- SETTLE_CYCLES, default 2: idle cycles between driving a vector and sampling f_in; 0 is legal and removes the settle phase.
- ERR_W, default 4: width of err_count; the counter saturates.
- clk  input  1  rising-edge clock.
- rst  input  1  reset. One clock; reset is asynchronous and active-high.
- start  input  1  run request; sampled only in IDLE.
- busy  output  1  high while a run is in progress, from DRIVE through SAMPLE of vector 7.
- x1, x2, x3  output  1 each  registered stimulus to the checked block; {x1,x2,x3} = vector index.
- f_in  input  1  f from the checked block.
- res_valid  output  1  result available; high in REPORT.
- res_ready  input  1  result consumer accept.
- err_count  output  ERR_W  mismatches in the last run, saturating at 2^ERR_W-1.
- first_err_vec  output  3  index of the first mismatching vector; 0 if there were none.
- pass  output  1  high when err_count == 0; meaningful while res_valid is high.

## Operation
- States: IDLE, DRIVE, SETTLE, SAMPLE, REPORT.
- IDLE:
  - If start is high, clear err_count, first_err_vec and the error-seen flag, set vec = 0, and go to DRIVE.
- DRIVE (1 cycle):
  - Register vec onto {x1,x2,x3}.
  - Go to SETTLE, or to SAMPLE if SETTLE_CYCLES == 0.
- SETTLE:
  - Count SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - Compare f_in against golden(vec).
  - On mismatch, increment err_count with saturation. If this is the first error, latch vec into first_err_vec.
  - If vec == 7, go to REPORT; otherwise increment vec and go to DRIVE.
- REPORT:
  - Hold res_valid and all result outputs stable until res_ready is high, then go to IDLE.
  - The handshake completes on the edge where res_valid and res_ready are both high.
- Boundary rules:
  - start is ignored outside IDLE, including in REPORT.
  - start held high across REPORT→IDLE begins a new run on the following IDLE cycle.
  - vec never wraps inside a run; the run ends after index 7.
  - After the first error, first_err_vec is never overwritten, even when err_count saturates.
  - x1/x2/x3 hold the last driven vector in REPORT and IDLE.
- Reset value of every output is 0, whenever rst is asserted:
  - busy, x1, x2, x3, res_valid, err_count, first_err_vec, pass.
- On reset, the state returns to IDLE and the run is abandoned; no result is produced for it.

## Timing
- start is sampled high in IDLE at edge k:
  - DRIVE is active after edge k.
  - busy rises at edge k.
- Each vector occupies SETTLE_CYCLES+2 cycles.
- REPORT (res_valid=1, busy=0) is entered at edge k + 8·(SETTLE_CYCLES+2), which is k+32 at the default.
- f_in is sampled SETTLE_CYCLES+1 edges after x changes, so the checked block has that many cycles to settle.
- Minimum turnaround:
  - REPORT lasts at least 1 cycle.
  - At least 1 IDLE cycle occurs before the next DRIVE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package mux_chk_pkg contains:
  - the state enum;
  - NUM_VEC = 8;
  - function golden_f(logic [2:0] v), returning ~(v[1] ? v[2] : v[0]).
- A single sub-module, settle_timer, is a loadable down-counter with a done flag. It is parameter-sized to $clog2(SETTLE_CYCLES+1) bits, minimum 1.
- All other logic lives in mux_vec_checker.

## Test plan
- Correct checked block connected, defaults → res_valid at start edge+32, err_count=0, pass=1, first_err_vec=0.
- f_in tied 0 → err_count=4 (vectors 0,2,3,4), first_err_vec=0, pass=0.
- f_in tied 1 → err_count=4 (vectors 1,5,6,7), first_err_vec=1.
- ERR_W=2, f_in = ~golden → err_count saturates at 3, first_err_vec=0; SETTLE_CYCLES=0 → res_valid at start edge+16.
- Hold res_ready low for 10 cycles in REPORT while pulsing start → outputs stable, no new run; raise res_ready → IDLE next edge, busy=0.
- Assert rst during SETTLE of vector 4 → all outputs 0 immediately and the state is IDLE; a new start runs a full clean 8-vector pass.

Source files
------------

// File: rtl/mux_chk_pkg.sv
// mux_chk_pkg: shared state encoding, vector count and golden function for the vector checker
package mux_chk_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, REPORT} state_e;
  localparam int NUM_VEC = 8;
  function automatic logic golden_f(logic [2:0] v);
    return ~(v[1] ? v[2] : v[0]);
  endfunction
endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down-counter that flags done once it reaches zero
module settle_timer
  import mux_chk_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;
  // reload on request, otherwise count down and park at zero
  always_comb begin
    cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  end
  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign done = cnt_q == '0;
endmodule

// File: rtl/mux_vec_checker.sv
// mux_vec_checker: walks all 8 input vectors, checks f against the golden function and reports via valid/ready
module mux_vec_checker
  import mux_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             x1,
  output logic             x2,
  output logic             x3,
  input  logic             f_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_err_vec,
  output logic             pass
);
  localparam int TW = SETTLE_CYCLES > 0 ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [TW-1:0] LOAD_V = TW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
  state_e           state_q, state_d;
  logic [2:0]       vec_q, vec_d, x_q, x_d, first_q, first_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             seen_q, seen_d, pass_q, pass_d, busy_q, busy_d, valid_q, valid_d;
  logic             tmr_load, tmr_done, mism;
  settle_timer #(.W(TW)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(tmr_load),
    .load_val(LOAD_V),
    .done(tmr_done)
  );
  // sequencing: drive a vector, let the checked block settle, sample and accumulate, then report
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    x_d      = x_q;
    err_d    = err_q;
    first_d  = first_q;
    seen_d   = seen_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    mism     = f_in != golden_f(vec_q);
    case (state_q)
      IDLE: if (start) begin
        err_d   = '0;
        first_d = '0;
        seen_d  = 1'b0;
        pass_d  = 1'b0;
        vec_d   = '0;
        state_d = DRIVE;
      end
      DRIVE: begin
        x_d      = vec_q;
        tmr_load = 1'b1;
        state_d  = SETTLE_CYCLES == 0 ? SAMPLE : SETTLE;
      end
      SETTLE: state_d = tmr_done ? SAMPLE : SETTLE;
      SAMPLE: begin
        if (mism) begin
          err_d = &err_q ? err_q : err_q + 1'b1;
          if (!seen_q) begin
            first_d = vec_q;
            seen_d  = 1'b1;
          end
        end
        if (vec_q == 3'(NUM_VEC - 1)) begin
          state_d = REPORT;
          pass_d  = err_d == '0;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = DRIVE;
        end
      end
      REPORT: state_d = res_ready ? IDLE : REPORT;
      default: state_d = IDLE;
    endcase
    busy_d  = state_d inside {DRIVE, SETTLE, SAMPLE};
    valid_d = state_d == REPORT;
  end
  // state and registered outputs; reset abandons any run in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      x_q     <= '0;
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      x_q     <= x_d;
      err_q   <= err_d;
      first_q <= first_d;
      seen_q  <= seen_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end
  assign {x1, x2, x3}  = x_q;
  assign busy          = busy_q;
  assign res_valid     = valid_q;
  assign err_count     = err_q;
  assign first_err_vec = first_q;
  assign pass          = pass_q;
endmodule

// File: tb/tb_mux_vec_checker.sv
// tb_mux_vec_checker: randomized fault-injection bench for two checker configurations against a mask-based model
module tb_mux_vec_checker;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, res_ready = 1'b0;
  logic [7:0] mask = '0;
  logic x1a, x2a, x3a, fa, busy_a, rv_a, pass_a;
  logic [3:0] err_a;
  logic [2:0] fv_a;
  logic x1b, x2b, x3b, fb, busy_b, rv_b, pass_b;
  logic [1:0] err_b;
  logic [2:0] fv_b;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  function automatic logic gold(input logic a, input logic b, input logic c);
    return ~(b ? a : c);
  endfunction

  assign fa = gold(x1a, x2a, x3a) ^ mask[{x1a, x2a, x3a}];
  assign fb = gold(x1b, x2b, x3b) ^ mask[{x1b, x2b, x3b}];

  mux_vec_checker dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy_a),
    .x1(x1a), .x2(x2a), .x3(x3a), .f_in(fa),
    .res_valid(rv_a), .res_ready(res_ready),
    .err_count(err_a), .first_err_vec(fv_a), .pass(pass_a)
  );

  mux_vec_checker #(.SETTLE_CYCLES(0), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .busy(busy_b),
    .x1(x1b), .x2(x2b), .x3(x3b), .f_in(fb),
    .res_valid(rv_b), .res_ready(res_ready),
    .err_count(err_b), .first_err_vec(fv_b), .pass(pass_b)
  );

  function automatic int exp_err(input logic [7:0] m, input int cap);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m[i]);
    return n > cap ? cap : n;
  endfunction

  function automatic logic [2:0] exp_first(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [7:0] tie_mask(input logic v);
    logic [7:0] m;
    logic [2:0] b;
    for (int i = 0; i < 8; i++) begin
      b = 3'(i);
      m[i] = gold(b[2], b[1], b[0]) ^ v;
    end
    return m;
  endfunction

  task automatic launch(input string nm);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if ({busy_a, busy_b} !== 2'b11) begin
      errors++;
      $display("FAIL %s busy_after_start got %b want 11", nm, {busy_a, busy_b});
    end
  endtask

  task automatic wait_report(output int la, output int lb);
    int c = 0;
    la = -1;
    lb = -1;
    while ((la < 0 || lb < 0) && c < 200) begin
      @(posedge clk);
      #1 c++;
      if (rv_a && la < 0) la = c;
      if (rv_b && lb < 0) lb = c;
    end
  endtask

  task automatic accept(input string nm);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    checks++;
    if ({rv_a, busy_a, rv_b, busy_b} !== 4'b0) begin
      errors++;
      $display("FAIL %s after_accept valid/busy got %b want 0000", nm, {rv_a, busy_a, rv_b, busy_b});
    end
  endtask

  task automatic check_result(input logic [7:0] m, input string nm);
    int ea = exp_err(m, 15);
    int eb = exp_err(m, 3);
    logic [2:0] ef = exp_first(m);
    checks++;
    if (err_a !== 4'(ea)) begin errors++; $display("FAIL %s err_a got %0d want %0d", nm, err_a, ea); end
    checks++;
    if (err_b !== 2'(eb)) begin errors++; $display("FAIL %s err_b got %0d want %0d", nm, err_b, eb); end
    checks++;
    if (fv_a !== ef || fv_b !== ef) begin errors++; $display("FAIL %s first got %0d/%0d want %0d", nm, fv_a, fv_b, ef); end
    checks++;
    if (pass_a !== (ea == 0) || pass_b !== (eb == 0)) begin errors++; $display("FAIL %s pass got %b/%b want %b", nm, pass_a, pass_b, ea == 0); end
    checks++;
    if ({x1a, x2a, x3a, x1b, x2b, x3b} !== 6'o77 || {busy_a, busy_b} !== 2'b00) begin
      errors++;
      $display("FAIL %s report_x_busy got %b%b%b/%b%b%b busy %b%b want 111/111 busy 00", nm, x1a, x2a, x3a, x1b, x2b, x3b, busy_a, busy_b);
    end
  endtask

  task automatic run_cmp(input logic [7:0] m, input string nm);
    int la, lb;
    mask = m;
    launch(nm);
    wait_report(la, lb);
    checks++;
    if (la != 32) begin errors++; $display("FAIL %s latency_a got %0d want 32", nm, la); end
    checks++;
    if (lb != 16) begin errors++; $display("FAIL %s latency_b got %0d want 16", nm, lb); end
    check_result(m, nm);
    accept(nm);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy_a, x1a, x2a, x3a, rv_a, err_a, fv_a, pass_a, busy_b, x1b, x2b, x3b, rv_b, err_b, fv_b, pass_b} !== '0) begin
      errors++;
      $display("FAIL reset outputs got nonzero want all 0");
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_correct();
    run_cmp(8'h00, "correct");
  endtask

  task automatic test_ties();
    run_cmp(tie_mask(1'b0), "tie0");
    checks++;
    if (err_a !== 4'd4 || fv_a !== 3'd0 || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL tie0 literal got err=%0d first=%0d pass=%b want 4 0 0", err_a, fv_a, pass_a);
    end
    run_cmp(tie_mask(1'b1), "tie1");
    checks++;
    if (err_a !== 4'd4 || fv_a !== 3'd1 || pass_a !== 1'b0) begin
      errors++;
      $display("FAIL tie1 literal got err=%0d first=%0d pass=%b want 4 1 0", err_a, fv_a, pass_a);
    end
  endtask

  task automatic test_saturate();
    run_cmp(8'hFF, "inverted");
    checks++;
    if (err_b !== 2'd3 || fv_b !== 3'd0 || err_a !== 4'd8) begin
      errors++;
      $display("FAIL inverted literal got err_b=%0d first_b=%0d err_a=%0d want 3 0 8", err_b, fv_b, err_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) run_cmp(8'($urandom), "random");
  endtask

  task automatic test_hold();
    int la, lb;
    logic [7:0] m = 8'($urandom) | 8'h40;
    mask = m;
    launch("hold");
    wait_report(la, lb);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = i[0];
      @(posedge clk);
      #1;
      checks++;
      if ({rv_a, busy_a, rv_b, busy_b} !== 4'b1010) begin
        errors++;
        $display("FAIL hold cycle %0d valid/busy got %b want 1010", i, {rv_a, busy_a, rv_b, busy_b});
      end
    end
    start = 1'b0;
    check_result(m, "hold");
    accept("hold");
  endtask

  task automatic test_back_to_back();
    int la, lb;
    mask = 8'h21;
    launch("b2b_first");
    wait_report(la, lb);
    @(negedge clk);
    start = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    checks++;
    if ({rv_a, busy_a} !== 2'b00) begin
      errors++;
      $display("FAIL b2b idle valid/busy got %b want 00", {rv_a, busy_a});
    end
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if ({busy_a, busy_b} !== 2'b11) begin
      errors++;
      $display("FAIL b2b restart busy got %b want 11", {busy_a, busy_b});
    end
    mask = 8'h84;
    wait_report(la, lb);
    checks++;
    if (la != 32 || lb != 16) begin
      errors++;
      $display("FAIL b2b latency got %0d/%0d want 32/16", la, lb);
    end
    check_result(8'h84, "b2b_second");
    accept("b2b");
  endtask

  task automatic test_reset_mid();
    mask = 8'hA5;
    launch("rst_mid");
    repeat (17) @(posedge clk);
    #2;
    checks++;
    if ({busy_a, x1a, x2a, x3a} !== 4'b1100) begin
      errors++;
      $display("FAIL rst_mid pre-reset busy/x got %b want 1100", {busy_a, x1a, x2a, x3a});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy_a, x1a, x2a, x3a, rv_a, err_a, fv_a, pass_a, busy_b, x1b, x2b, x3b, rv_b, err_b, fv_b, pass_b} !== '0) begin
      errors++;
      $display("FAIL rst_mid outputs got nonzero want all 0");
    end
    @(negedge clk);
    rst = 1'b0;
    run_cmp(8'h00, "rst_mid_clean");
  endtask

  initial begin
    test_reset();
    test_correct();
    test_ties();
    test_saturate();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
